// File: rtl/t07_exec_sequencer_if.sv
// Handshake and control bundle between the execution sequencer and its surroundings:
// fetch path, control unit, memory handler and FPU.
interface t07_exec_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             fetch_ack;
    logic             cu_memRead;
    logic             cu_memWrite;
    logic             cu_regWrite;
    logic             cu_regEnable_FPU;
    logic [1:0]       cu_FPUWrite;
    logic             cu_invalid_Op;
    logic             mem_done;
    logic             fpu_done;
    logic             trap_clr;

    logic             fetch_req;
    logic             ir_load;
    logic             mem_start;
    logic             fpu_start;
    logic             reg_wb_en;
    logic             fpu_wb_en;
    logic             pc_en;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    // Sequencer side
    modport master (
        input  run, fetch_ack,
        input  cu_memRead, cu_memWrite, cu_regWrite, cu_regEnable_FPU,
        input  cu_FPUWrite, cu_invalid_Op,
        input  mem_done, fpu_done, trap_clr,
        output fetch_req, ir_load, mem_start, fpu_start,
        output reg_wb_en, fpu_wb_en, pc_en,
        output trap, trap_cause, state, retired
    );

    // Environment side: fetch path, control unit, memory handler, FPU
    modport slave (
        output run, fetch_ack,
        output cu_memRead, cu_memWrite, cu_regWrite, cu_regEnable_FPU,
        output cu_FPUWrite, cu_invalid_Op,
        output mem_done, fpu_done, trap_clr,
        input  fetch_req, ir_load, mem_start, fpu_start,
        input  reg_wb_en, fpu_wb_en, pc_en,
        input  trap, trap_cause, state, retired
    );
endinterface

// File: rtl/t07_exec_sequencer.sv
// Multi-cycle execution sequencer: fetch, decode, memory/FPU wait, single-cycle
// writeback, with timeout and invalid-opcode trapping and a retired-instruction counter.
module t07_exec_sequencer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input logic                  clk,
    input logic                  rst,
    t07_exec_sequencer_if.master bus
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_FPU    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_INVALID = 2'b01;
    localparam logic [1:0] CAUSE_MEM_TO  = 2'b10;
    localparam logic [1:0] CAUSE_FPU_TO  = 2'b11;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_d;
    logic [CNT_W-1:0]  retired_q;
    logic [CNT_W-1:0]  retired_d;
    logic [1:0]        cause_q;
    logic [1:0]        cause_d;

    logic is_mem;
    logic is_fpu;
    logic fetch_req;
    logic ir_load;
    logic mem_start;
    logic fpu_start;
    logic reg_wb_en;
    logic fpu_wb_en;
    logic pc_en;

    // Memory wins over the FPU path when both are flagged.
    assign is_mem = bus.cu_memRead | bus.cu_memWrite;
    assign is_fpu = bus.cu_regEnable_FPU & ~is_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_cnt  <= '0;
            retired_q <= '0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            wait_cnt  <= wait_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_cnt;
        retired_d = retired_q;
        cause_d   = cause_q;
        fetch_req = 1'b0;
        ir_load   = 1'b0;
        mem_start = 1'b0;
        fpu_start = 1'b0;
        reg_wb_en = 1'b0;
        fpu_wb_en = 1'b0;
        pc_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                fetch_req = 1'b1;
                if (bus.fetch_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                wait_d = '0;
                if (bus.cu_invalid_Op) begin
                    cause_d = CAUSE_INVALID;
                    state_d = S_TRAP;
                end else if (is_mem) begin
                    mem_start = 1'b1;
                    state_d   = S_MEM;
                end else if (is_fpu) begin
                    fpu_start = 1'b1;
                    state_d   = S_FPU;
                end else begin
                    state_d = S_WB;
                end
            end

            // A done on the last allowed wait cycle still completes normally.
            S_MEM: begin
                if (bus.mem_done) begin
                    state_d = S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    cause_d = CAUSE_MEM_TO;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_cnt + WAIT_W'(1);
                end
            end

            S_FPU: begin
                if (bus.fpu_done) begin
                    state_d = S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    cause_d = CAUSE_FPU_TO;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_cnt + WAIT_W'(1);
                end
            end

            S_WB: begin
                pc_en     = 1'b1;
                reg_wb_en = bus.cu_regWrite & ~is_fpu;
                fpu_wb_en = is_fpu & (bus.cu_FPUWrite != 2'b00);
                retired_d = retired_q + CNT_W'(1);
                state_d   = bus.run ? S_FETCH : S_IDLE;
            end

            S_TRAP: begin
                if (bus.trap_clr) begin
                    cause_d = CAUSE_NONE;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.fetch_req  = fetch_req;
    assign bus.ir_load    = ir_load;
    assign bus.mem_start  = mem_start;
    assign bus.fpu_start  = fpu_start;
    assign bus.reg_wb_en  = reg_wb_en;
    assign bus.fpu_wb_en  = fpu_wb_en;
    assign bus.pc_en      = pc_en;
    assign bus.trap       = (state_q == S_TRAP);
    assign bus.trap_cause = cause_q;
    assign bus.state      = state_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_t07_exec_sequencer.sv
// Randomized bench for t07_exec_sequencer: each instruction is expanded into its
// expected per-cycle timeline from the documented latencies and compared cycle by cycle.
module tb_t07_exec_sequencer;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_FPU    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    // Pulse vector order: fetch_req, ir_load, mem_start, fpu_start, reg_wb_en, fpu_wb_en, pc_en
    localparam logic [6:0] P_NONE = 7'b0000000;
    localparam logic [6:0] P_FREQ = 7'b1000000;
    localparam logic [6:0] P_IRL  = 7'b0100000;
    localparam logic [6:0] P_MS   = 7'b0010000;
    localparam logic [6:0] P_FS   = 7'b0001000;
    localparam logic [6:0] P_RWB  = 7'b0000100;
    localparam logic [6:0] P_FWB  = 7'b0000010;
    localparam logic [6:0] P_PC   = 7'b0000001;

    localparam int K_ALU = 0;
    localparam int K_MEM = 1;
    localparam int K_FPU = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    t07_exec_sequencer_if #(.CNT_W(CNT_W)) bus ();

    t07_exec_sequencer #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [CNT_W-1:0] ref_ret;
    logic [1:0]       ref_cause;
    bit               in_idle;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called right after a negedge with inputs already driven; checks, then moves to the next negedge.
    task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [6:0] p,
                              input logic trp, input logic [1:0] cause);
        #1;
        check_eq({tag, "/state"}, 32'(bus.state), 32'(st));
        check_eq({tag, "/pulses"}, 32'({bus.fetch_req, bus.ir_load, bus.mem_start, bus.fpu_start,
                                        bus.reg_wb_en, bus.fpu_wb_en, bus.pc_en}), 32'(p));
        check_eq({tag, "/trap"}, 32'(bus.trap), 32'(trp));
        check_eq({tag, "/cause"}, 32'(bus.trap_cause), 32'(cause));
        check_eq({tag, "/retired"}, 32'(bus.retired), 32'(ref_ret));
        @(negedge clk);
    endtask

    task automatic noise_cu();
        bus.cu_memRead       = 1'($urandom);
        bus.cu_memWrite      = 1'($urandom);
        bus.cu_regWrite      = 1'($urandom);
        bus.cu_regEnable_FPU = 1'($urandom);
        bus.cu_FPUWrite      = 2'($urandom);
        bus.cu_invalid_Op    = 1'($urandom);
    endtask

    task automatic set_cu(input int kind, input bit invalid, input bit regw, input logic [1:0] fpuw);
        int r;
        r = $urandom_range(0, 2);
        bus.cu_memRead       = (kind == K_MEM) && (r != 1);
        bus.cu_memWrite      = (kind == K_MEM) && (r != 0);
        bus.cu_regEnable_FPU = (kind == K_FPU) || ((kind == K_MEM) && 1'($urandom));
        bus.cu_regWrite      = regw;
        bus.cu_FPUWrite      = fpuw;
        bus.cu_invalid_Op    = invalid;
    endtask

    task automatic trap_phase();
        int k;
        bus.mem_done = 1'b0;
        bus.fpu_done = 1'b0;
        k = $urandom_range(1, 3);
        for (int i = 0; i < k; i++) begin
            bus.trap_clr  = 1'b0;
            bus.run       = 1'($urandom);
            bus.fetch_ack = 1'($urandom);
            noise_cu();
            expect_cyc("trap_hold", ST_TRAP, P_NONE, 1'b1, ref_cause);
        end
        bus.trap_clr = 1'b1;
        bus.run      = 1'($urandom);
        expect_cyc("trap_clr", ST_TRAP, P_NONE, 1'b1, ref_cause);
        bus.trap_clr = 1'b0;
        bus.run      = 1'b0;
        ref_cause    = 2'b00;
        expect_cyc("post_trap", ST_IDLE, P_NONE, 1'b0, 2'b00);
        in_idle = 1'b1;
    endtask

    // n: wait cycle carrying done (n > TIMEOUT means never); rst_at: wait cycle to assert rst (0 = none)
    task automatic instr(input int kind, input int ack_wait, input int n, input bit invalid,
                         input bit regw, input logic [1:0] fpuw, input bit drop_run, input int rst_at);
        logic [6:0] p;
        logic [2:0] wst;
        bus.mem_done = 1'b0;
        bus.fpu_done = 1'b0;
        bus.trap_clr = 1'b0;
        if (in_idle) begin
            bus.run       = 1'b1;
            bus.fetch_ack = 1'($urandom);
            noise_cu();
            expect_cyc("idle", ST_IDLE, P_NONE, 1'b0, 2'b00);
        end
        for (int i = 0; i <= ack_wait; i++) begin
            bus.run       = 1'b1;
            bus.fetch_ack = (i == ack_wait);
            noise_cu();
            expect_cyc("fetch", ST_FETCH, (i == ack_wait) ? (P_FREQ | P_IRL) : P_FREQ, 1'b0, 2'b00);
        end
        bus.fetch_ack = 1'($urandom);
        set_cu(kind, invalid, regw, fpuw);
        if (drop_run && kind == K_ALU) bus.run = 1'b0;
        if (invalid)            p = P_NONE;
        else if (kind == K_MEM) p = P_MS;
        else if (kind == K_FPU) p = P_FS;
        else                    p = P_NONE;
        expect_cyc("decode", ST_DECODE, p, 1'b0, 2'b00);
        if (invalid) begin
            ref_cause = 2'b01;
            trap_phase();
            return;
        end
        if (kind != K_ALU) begin
            wst = (kind == K_MEM) ? ST_MEM : ST_FPU;
            for (int w = 1; w <= TIMEOUT; w++) begin
                bus.fetch_ack = 1'($urandom);
                if (drop_run && w == 1) bus.run = 1'b0;
                if (w == rst_at) begin
                    bus.mem_done = 1'b0;
                    bus.fpu_done = 1'b0;
                    rst = 1'b1;
                    expect_cyc("wait_rst", wst, P_NONE, 1'b0, 2'b00);
                    rst       = 1'b0;
                    bus.run   = 1'b0;
                    ref_ret   = '0;
                    ref_cause = 2'b00;
                    expect_cyc("after_rst", ST_IDLE, P_NONE, 1'b0, 2'b00);
                    in_idle = 1'b1;
                    return;
                end
                if (kind == K_MEM) begin
                    bus.mem_done = (w == n);
                    bus.fpu_done = 1'($urandom);
                end else begin
                    bus.fpu_done = (w == n);
                    bus.mem_done = 1'($urandom);
                end
                expect_cyc("wait", wst, P_NONE, 1'b0, 2'b00);
                if (w == n) break;
            end
            if (n > TIMEOUT) begin
                ref_cause = (kind == K_MEM) ? 2'b10 : 2'b11;
                trap_phase();
                return;
            end
        end
        bus.mem_done  = 1'b0;
        bus.fpu_done  = 1'b0;
        bus.fetch_ack = 1'($urandom);
        p = P_PC;
        if (regw && kind != K_FPU)                p = p | P_RWB;
        if (kind == K_FPU && fpuw != 2'b00)       p = p | P_FWB;
        expect_cyc("wb", ST_WB, p, 1'b0, 2'b00);
        ref_ret = ref_ret + 1'b1;
        in_idle = !bus.run;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.fetch_ack = 1'b0;
        bus.mem_done  = 1'b0;
        bus.fpu_done  = 1'b0;
        bus.trap_clr  = 1'b0;
        bus.cu_memRead       = 1'b0;
        bus.cu_memWrite      = 1'b0;
        bus.cu_regWrite      = 1'b0;
        bus.cu_regEnable_FPU = 1'b0;
        bus.cu_FPUWrite      = 2'b00;
        bus.cu_invalid_Op    = 1'b0;
        ref_ret   = '0;
        ref_cause = 2'b00;
        in_idle   = 1'b1;

        @(negedge clk);
        expect_cyc("reset", ST_IDLE, P_NONE, 1'b0, 2'b00);
        rst = 1'b0;
        expect_cyc("idle_norun", ST_IDLE, P_NONE, 1'b0, 2'b00);

        // Directed scenarios
        instr(K_ALU, 0, 0, 1'b0, 1'b1, 2'b00, 1'b0, 0);
        instr(K_MEM, 0, 4, 1'b0, 1'b1, 2'b00, 1'b0, 0);
        instr(K_FPU, 0, TIMEOUT + 1, 1'b0, 1'b1, 2'b01, 1'b0, 0);
        instr(K_ALU, 0, 0, 1'b1, 1'b1, 2'b00, 1'b0, 0);
        instr(K_MEM, 1, TIMEOUT, 1'b0, 1'b1, 2'b00, 1'b0, 0);
        instr(K_MEM, 0, TIMEOUT + 1, 1'b0, 1'b1, 2'b00, 1'b0, 0);
        instr(K_FPU, 2, 3, 1'b0, 1'b0, 2'b10, 1'b0, 0);
        instr(K_MEM, 0, 3, 1'b0, 1'b1, 2'b00, 1'b1, 0);
        instr(K_FPU, 0, 5, 1'b0, 1'b1, 2'b01, 1'b0, 2);

        // Randomized instruction mix
        for (int t = 0; t < 300; t++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 2);
            n    = ($urandom_range(0, 5) == 0) ? TIMEOUT + 1 : $urandom_range(1, TIMEOUT);
            instr(kind, $urandom_range(0, 3), n, $urandom_range(0, 9) == 0, 1'($urandom),
                  2'($urandom), $urandom_range(0, 4) == 0,
                  ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0);
        end

        // Enough ALU retirements to carry the counter through its wrap point
        for (int t = 0; t < 260; t++) begin
            instr(K_ALU, 0, 0, 1'b0, 1'($urandom), 2'b00, 1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
